// File: rtl/serial_frame_tx.sv
// serial_frame_tx: loads a header/payload pair and shifts it out MSB first on
// ser_out, framed by one start bit (0) and GAP idle-high bits.
// Optional build macro SERIAL_FRAME_TX_BUF_EN adds a one-entry holding buffer
// so a second frame can be accepted while one is on the line and sent with no
// extra idle cycle. With the macro undefined the block accepts only in IDLE.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle high, waiting for a frame (no buffered frame exists)
// S_START | start bit (0) on the line
// S_HDR   | header bits, MSB first, HDR_W cycles
// S_PAY   | payload bits, MSB first, PAY_W cycles
// S_GAP   | idle-high guard bits, GAP cycles; frame_done in the last one
module serial_frame_tx #(
   parameter int HDR_W = 8,
   parameter int PAY_W = 7,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [HDR_W-1:0] hdr,
   input  logic [PAY_W-1:0] pay,
   output logic             ser_out,
   output logic             busy,
   output logic             frame_done
);

   localparam int MAX_HP = (HDR_W > PAY_W) ? HDR_W : PAY_W;
   localparam int MAX_W  = (MAX_HP > GAP) ? MAX_HP : GAP;
   localparam int CW     = $clog2(MAX_W) + 1;
   localparam int SW     = HDR_W + PAY_W;

   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_HDR = CW'(HDR_W);
   localparam logic [CW-1:0] CNT_PAY = CW'(PAY_W);
   localparam logic [CW-1:0] CNT_GAP = CW'(GAP);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_HDR   = 3'd2;
   localparam logic [2:0] S_PAY   = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] sh_q, sh_d;
   logic          ser_q, ser_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          ready_q, ready_d;
   logic          xfer;
   logic          tc;
   logic          load_in;
`ifdef SERIAL_FRAME_TX_BUF_EN
   logic [SW-1:0] buf_q, buf_d;
   logic          bufv_q, bufv_d;
   logic          load_buf;
   logic          buf_wr;
`endif

   assign xfer = in_valid & ready_q;
   assign tc   = (cnt_q == CNT_ONE);

   assign in_ready   = ready_q;
   assign ser_out    = ser_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   // Sequencing: state transitions and per-field down-counter reloads.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - CNT_ONE;
      load_in = 1'b0;
`ifdef SERIAL_FRAME_TX_BUF_EN
      load_buf = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (xfer) begin
               state_d = S_START;
               cnt_d   = CNT_ONE;
               load_in = 1'b1;
            end
         end
         S_START: begin
            state_d = S_HDR;
            cnt_d   = CNT_HDR;
         end
         S_HDR: begin
            if (tc) begin
               state_d = S_PAY;
               cnt_d   = CNT_PAY;
            end
         end
         S_PAY: begin
            if (tc) begin
               state_d = S_GAP;
               cnt_d   = CNT_GAP;
            end
         end
         S_GAP: begin
            if (tc) begin
`ifdef SERIAL_FRAME_TX_BUF_EN
               if (bufv_q) begin
                  state_d  = S_START;
                  cnt_d    = CNT_ONE;
                  load_buf = 1'b1;
               end else if (xfer) begin
                  state_d = S_START;
                  cnt_d   = CNT_ONE;
                  load_in = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
`else
               if (xfer) begin
                  state_d = S_START;
                  cnt_d   = CNT_ONE;
                  load_in = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef SERIAL_FRAME_TX_BUF_EN
   // Holding buffer: an accepted frame that cannot go straight to the shifter
   // parks here; it may be refilled in the same cycle it is consumed.
   always_comb begin
      buf_wr = xfer & ~load_in;
      bufv_d = buf_wr | (bufv_q & ~load_buf);
      buf_d  = buf_wr ? {hdr, pay} : buf_q;
   end
`endif

   // Shift register: capture on frame start, shift once per data bit sent.
   always_comb begin
      sh_d = sh_q;
      if (load_in) begin
         sh_d = {hdr, pay};
`ifdef SERIAL_FRAME_TX_BUF_EN
      end else if (load_buf) begin
         sh_d = buf_q;
`endif
      end else if ((state_d == S_HDR) || (state_d == S_PAY)) begin
         sh_d = {sh_q[SW-2:0], 1'b0};
      end
   end

   // Output decode from the next state so every output comes from a flop.
   always_comb begin
      ser_d = 1'b1;
      if (state_d == S_START) begin
         ser_d = 1'b0;
      end else if ((state_d == S_HDR) || (state_d == S_PAY)) begin
         ser_d = sh_q[SW-1];
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_GAP) && (cnt_d == CNT_ONE);
`ifdef SERIAL_FRAME_TX_BUF_EN
      // Open up in the last GAP cycle too: the buffer empties at that edge.
      ready_d = ~bufv_d | ((state_d == S_GAP) && (cnt_d == CNT_ONE));
`else
      ready_d = (state_d == S_IDLE);
`endif
   end

   // State and output registers; reset drives the line idle high at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         ser_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         ser_q   <= ser_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

`ifdef SERIAL_FRAME_TX_BUF_EN
   // Buffer registers; a reset discards any pending frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q  <= '0;
         bufv_q <= 1'b0;
      end else begin
         buf_q  <= buf_d;
         bufv_q <= bufv_d;
      end
   end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table of single frames with hand-written bit
// streams, a receiver-side scoreboard, and corner sequences (held in_valid,
// input toggling, mid-frame reset, GAP=3 back-to-back).
module tb_serial_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] hdr = '0;
   logic [6:0] pay = '0;
   logic       in_ready, ser_out, busy, frame_done;

   logic       v3 = 1'b0;
   logic [7:0] h3 = '0;
   logic [6:0] p3 = '0;
   logic       rdy3, ser3, busy3, fd3;

`ifdef SERIAL_FRAME_TX_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   always #5 clk = ~clk;

   serial_frame_tx dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .hdr(hdr), .pay(pay), .ser_out(ser_out), .busy(busy),
      .frame_done(frame_done)
   );

   serial_frame_tx #(.HDR_W(8), .PAY_W(7), .GAP(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
      .hdr(h3), .pay(p3), .ser_out(ser3), .busy(busy3),
      .frame_done(fd3)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [14:0] exp_q[$];
   int          last_gap  = 0;
   int          rx_frames = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Receiver-side scoreboard: decode frames from ser_out and compare with
   // the frames queued when they were accepted.
   initial begin
      int          st;
      int          n;
      int          gapn;
      logic [14:0] sh;
      st = 0; n = 0; gapn = 0; sh = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            st = 0;
         end else begin
            case (st)
               0: if (ser_out == 1'b0) begin st = 1; n = 0; sh = '0; end
               1: begin
                  sh = {sh[13:0], ser_out};
                  n++;
                  if (n == 15) begin
                     rx_frames++;
                     if (exp_q.size() == 0) check("sb_unexpected_frame", {17'd0, sh}, 32'hFFFF_FFFF);
                     else check("sb_frame", {17'd0, sh}, {17'd0, exp_q.pop_front()});
                     st = 2;
                     gapn = 0;
                  end
               end
               default: begin
                  if (ser_out == 1'b0) begin
                     last_gap = gapn;
                     st = 1; n = 0; sh = '0;
                  end else begin
                     gapn++;
                  end
               end
            endcase
         end
      end
   end

   task automatic drive(input logic [7:0] h, input logic [6:0] p);
      in_valid = 1'b1;
      hdr = h;
      pay = p;
   endtask

   // Call away from a clock edge; returns #1 after the transfer edge.
   task automatic wait_accept(input logic [14:0] exp, output int waited);
      logic r;
      waited = 0;
      forever begin
         r = in_ready;
         @(posedge clk);
         waited++;
         if (r) break;
         if (waited > 100) break;
         #1;
      end
      if (r) exp_q.push_back(exp);
      else check("accept_timeout", 32'd1, 32'd0);
      #1;
   endtask

   // Watch a single frame from the cycle after the transfer edge.
   task automatic measure(input logic [15:0] exp_s, input bit rnd, input string tag);
      int busy_n, fd_n, fd_at, bit_err;
      logic b1, b18;
      busy_n = 0; fd_n = 0; fd_at = 0; bit_err = 0; b1 = 1'b0; b18 = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (rnd) begin hdr = 8'($urandom); pay = 7'($urandom); end
         if (busy) busy_n++;
         if (c == 1) b1 = busy;
         if (c == 18) b18 = busy;
         if (frame_done) begin fd_n++; fd_at = c; end
         if (c <= 16) begin
            if (ser_out !== exp_s[16-c]) bit_err++;
         end else if (ser_out !== 1'b1) begin
            bit_err++;
         end
      end
      check({tag, "_bits"}, bit_err, 0);
      check({tag, "_busy_cycles"}, busy_n, 17);
      check({tag, "_busy_first"}, {31'd0, b1}, 1);
      check({tag, "_busy_after"}, {31'd0, b18}, 0);
      check({tag, "_done_count"}, fd_n, 1);
      check({tag, "_done_cycle"}, fd_at, 17);
   endtask

   typedef struct {
      logic [7:0]  h;
      logic [6:0]  p;
      logic [15:0] s;
   } vec_t;

   initial begin
      vec_t vt[5];
      int   w;
      int   fd_n;
      int   hi_err;
      int   frames0;

      vt[0] = '{8'hA5, 7'h5A, 16'b0_10100101_1011010};
      vt[1] = '{8'hFF, 7'h00, 16'b0_11111111_0000000};
      vt[2] = '{8'h00, 7'h7F, 16'b0_00000000_1111111};
      vt[3] = '{8'h3C, 7'h55, 16'b0_00111100_1010101};
      vt[4] = '{8'h81, 7'h01, 16'b0_10000001_0000001};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ser_out", {31'd0, ser_out}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_frame_done", {31'd0, frame_done}, 0);
      check("rst_in_ready", {31'd0, in_ready}, 0);
      check("rst_ser3", {31'd0, ser3}, 1);
      rst = 1'b0;
      #1 check("ready_before_edge", {31'd0, in_ready}, 0);
      @(negedge clk);
      check("ready_after_edge", {31'd0, in_ready}, 1);
      check("ready3_after_edge", {31'd0, rdy3}, 1);

      // table of single frames
      foreach (vt[i]) begin
         drive(vt[i].h, vt[i].p);
         wait_accept(vt[i].s[14:0], w);
         in_valid = 1'b0;
         check("accept_latency", w, 1);
         measure(vt[i].s, 1'b0, "vec");
      end

      // inputs toggling after the transfer must not disturb the frame
      drive(8'hFF, 7'h00);
      wait_accept(15'b11111111_0000000, w);
      in_valid = 1'b0;
      measure(16'b0_11111111_0000000, 1'b1, "toggle");

      // in_valid held high across two different frames
      frames0 = rx_frames;
      drive(8'hA5, 7'h5A);
      wait_accept(15'b10100101_1011010, w);
      drive(8'h3C, 7'h55);
      wait_accept(15'b00111100_1010101, w);
      in_valid = 1'b0;
      if (BUF) check("held_second_early", {31'd0, (w <= 9)}, 1);
      else check("held_second_wait", w, 18);
      repeat (40) @(negedge clk);
      check("held_gap", last_gap, BUF ? 1 : 2);
      check("held_frames", rx_frames - frames0, 2);
      check("held_queue_empty", exp_q.size(), 0);

      // reset in the middle of the header
      drive(8'hA5, 7'h5A);
      wait_accept(15'b10100101_1011010, w);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_bit_before_rst", {31'd0, ser_out}, 0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ser_out", {31'd0, ser_out}, 1);
      check("mid_rst_busy", {31'd0, busy}, 0);
      check("mid_rst_ready", {31'd0, in_ready}, 0);
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      fd_n = 0; hi_err = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (frame_done) fd_n++;
         if (ser_out !== 1'b1) hi_err++;
      end
      check("mid_no_done", fd_n, 0);
      check("mid_line_idle", hi_err, 0);
      drive(8'hA5, 7'h5A);
      wait_accept(15'b10100101_1011010, w);
      in_valid = 1'b0;
      measure(16'b0_10100101_1011010, 1'b0, "after_rst");

      // GAP=3 instance, back-to-back frames
      begin
         logic        r, acc2, drop;
         logic        s [1:60];
         int          k, idle, bit_err, f3;
         logic [14:0] rx;
         v3 = 1'b1; h3 = 8'h81; p3 = 7'h01;
         k = 0;
         forever begin
            r = rdy3;
            @(posedge clk);
            k++;
            if (r || k > 100) break;
            #1;
         end
         check("g3_first_accept", {31'd0, r}, 1);
         #1;
         h3 = 8'h3C; p3 = 7'h55;
         acc2 = 1'b0; drop = 1'b0; f3 = 0;
         for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            s[c] = ser3;
            if (fd3) f3++;
            if (drop) begin v3 = 1'b0; drop = 1'b0; end
            else if (!acc2 && rdy3) begin acc2 = 1'b1; drop = 1'b1; end
         end
         v3 = 1'b0;
         bit_err = 0;
         for (int c = 1; c <= 16; c++)
            if (s[c] !== ((c == 1) ? 1'b0 : ((c == 2 || c == 9 || c == 16) ? 1'b1 : 1'b0))) bit_err++;
         check("g3_first_bits", bit_err, 0);
         idle = 0;
         k = 17;
         while (k <= 45 && s[k] === 1'b1) begin idle++; k++; end
         check("g3_idle", idle, BUF ? 3 : 4);
         rx = '0;
         for (int c = 1; c <= 15; c++) rx = {rx[13:0], s[k + c]};
         check("g3_second_frame", {17'd0, rx}, {17'd0, 15'b00111100_1010101});
         check("g3_done_count", f3, 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
